// File: rtl/usb_ep_dbuf.sv
// ---------------------------------------------------------------------------
// usb_ep_dbuf
// Double-buffered (ping-pong) USB endpoint packet buffer. Two banks share one
// 32-bit-wide RAM; the bank index is the word-address MSB. The writer fills
// bank wb and commits it as a packet, and the reader drains bank rb and
// releases it. Each bank is either EMPTY or FULL.
//
// Ports
//   i_clk         single clock
//   i_rst_n       asynchronous active-low reset
//   i_wr_addr     word offset inside the current write bank (AWW bits)
//   i_wr_data     write data (WWIDTH bits)
//   i_wr_en       write strobe
//   i_wr_commit   close the current write bank as a packet
//   i_wr_len      packet byte length, sampled with i_wr_commit
//   o_wr_rdy      current write bank is free
//   i_rd_addr     word offset inside the current read bank (ARW bits)
//   i_rd_en       read strobe, data appears on o_rd_data one edge later
//   o_rd_data     registered read data, held while i_rd_en is low
//   o_rd_avail    current read bank holds a committed packet
//   o_rd_len      byte length of the current read packet (0 if none)
//   i_rd_release  free the current read bank
//   i_flush       synchronous discard of all packets
// ---------------------------------------------------------------------------
module usb_ep_dbuf #(
   parameter int WWIDTH  = 8,
   parameter int RWIDTH  = 32,
   parameter int BANK_AW = 6,
   localparam int AWW    = BANK_AW - $clog2(WWIDTH / 8),
   localparam int ARW    = BANK_AW - $clog2(RWIDTH / 8)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [AWW-1:0]    i_wr_addr,
   input  logic [WWIDTH-1:0] i_wr_data,
   input  logic              i_wr_en,
   input  logic              i_wr_commit,
   input  logic [BANK_AW:0]  i_wr_len,
   output logic              o_wr_rdy,
   input  logic [ARW-1:0]    i_rd_addr,
   input  logic              i_rd_en,
   output logic [RWIDTH-1:0] o_rd_data,
   output logic              o_rd_avail,
   output logic [BANK_AW:0]  o_rd_len,
   input  logic              i_rd_release,
   input  logic              i_flush
);

   localparam int RAM_WORDS = 1 << (BANK_AW - 1);
   localparam logic [BANK_AW:0] BANK_BYTES = {1'b1, {BANK_AW{1'b0}}};

   logic [31:0]        r_mem [0:RAM_WORDS-1];
   logic               r_wb;
   logic               r_rb;
   logic [1:0]         r_full;
   logic [BANK_AW:0]   r_len0;
   logic [BANK_AW:0]   r_len1;
   logic [31:0]        r_rdWord;

   logic [BANK_AW-2:0] w_wrWordAddr;
   logic [BANK_AW-2:0] w_rdWordAddr;
   logic [3:0]         w_byteEn;
   logic [31:0]        w_wrWord;
   logic               w_wrFire;
   logic               w_commitFire;
   logic               w_releaseFire;
   logic [1:0]         w_nextFull;
   logic [BANK_AW:0]   w_clipLen;

   assign o_wr_rdy   = ~r_full[r_wb];
   assign o_rd_avail = r_full[r_rb];
   assign o_rd_len   = o_rd_avail ? (r_rb ? r_len1 : r_len0) : '0;

   // Flush wins over any same-cycle write, commit or release.
   assign w_wrFire      = i_wr_en      & o_wr_rdy   & ~i_flush;
   assign w_commitFire  = i_wr_commit  & o_wr_rdy   & ~i_flush;
   assign w_releaseFire = i_rd_release & o_rd_avail & ~i_flush;
   assign w_clipLen     = (i_wr_len > BANK_BYTES) ? BANK_BYTES : i_wr_len;

   // Byte writes replicate the byte across all lanes and mask the others off.
   generate
      if (WWIDTH == 8) begin : g_wr8
         assign w_wrWordAddr = {r_wb, i_wr_addr[AWW-1:2]};
         assign w_byteEn     = 4'b0001 << i_wr_addr[1:0];
         assign w_wrWord     = {4{i_wr_data}};
      end else begin : g_wr32
         assign w_wrWordAddr = {r_wb, i_wr_addr};
         assign w_byteEn     = 4'b1111;
         assign w_wrWord     = i_wr_data;
      end
   endgenerate

   // Commit and release always target different banks, so both may land.
   always_comb begin
      w_nextFull = r_full;
      if (w_commitFire)  w_nextFull[r_wb] = 1'b1;
      if (w_releaseFire) w_nextFull[r_rb] = 1'b0;
   end

   // Bank bookkeeping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_full <= 2'b00;
         r_wb   <= 1'b0;
         r_rb   <= 1'b0;
         r_len0 <= '0;
         r_len1 <= '0;
      end else if (i_flush) begin
         r_full <= 2'b00;
         r_wb   <= 1'b0;
         r_rb   <= 1'b0;
      end else begin
         r_full <= w_nextFull;
         if (w_commitFire) begin
            r_wb <= ~r_wb;
            if (r_wb) r_len1 <= w_clipLen;
            else      r_len0 <= w_clipLen;
         end
         if (w_releaseFire) r_rb <= ~r_rb;
      end
   end

   // Packet RAM has no reset, so it can map onto a block RAM.
   always_ff @(posedge i_clk) begin
      if (w_wrFire) begin
         for (int b = 0; b < 4; b++) begin
            if (w_byteEn[b]) r_mem[w_wrWordAddr][b*8 +: 8] <= w_wrWord[b*8 +: 8];
         end
      end
   end

   // The capture register loads only on i_rd_en, so o_rd_data holds its value
   // otherwise. A read of a word being written in the same cycle returns the
   // old contents.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     r_rdWord <= '0;
      else if (i_rd_en) r_rdWord <= r_mem[w_rdWordAddr];
   end

   generate
      if (RWIDTH == 8) begin : g_rd8
         logic [1:0] r_lane;

         assign w_rdWordAddr = {r_rb, i_rd_addr[ARW-1:2]};

         // The lane is registered with the word, so the byte select matches
         // the captured data.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)     r_lane <= 2'b00;
            else if (i_rd_en) r_lane <= i_rd_addr[1:0];
         end

         assign o_rd_data = r_rdWord[r_lane*8 +: 8];
      end else begin : g_rd32
         assign w_rdWordAddr = {r_rb, i_rd_addr};
         assign o_rd_data    = r_rdWord;
      end
   endgenerate

endmodule

// File: tb/tb_usb_ep_dbuf.sv
// ---------------------------------------------------------------------------
// tb_usb_ep_dbuf
// Directed bench for usb_ep_dbuf with default parameters (8-bit write port,
// 32-bit read port, 64-byte banks). Each feature has its own task. The tasks
// run in sequence, and the bank pointers carry over from one task to the next.
// ---------------------------------------------------------------------------
module tb_usb_ep_dbuf;

   logic        clk = 1'b0;
   logic        rstN;
   logic [5:0]  wrAddr;
   logic [7:0]  wrData;
   logic        wrEn;
   logic        wrCommit;
   logic [6:0]  wrLen;
   logic        wrRdy;
   logic [3:0]  rdAddr;
   logic        rdEn;
   logic [31:0] rdData;
   logic        rdAvail;
   logic [6:0]  rdLen;
   logic        rdRelease;
   logic        flush;

   int tests = 0;
   int fails = 0;

   usb_ep_dbuf dut (
      .i_clk        (clk),
      .i_rst_n      (rstN),
      .i_wr_addr    (wrAddr),
      .i_wr_data    (wrData),
      .i_wr_en      (wrEn),
      .i_wr_commit  (wrCommit),
      .i_wr_len     (wrLen),
      .o_wr_rdy     (wrRdy),
      .i_rd_addr    (rdAddr),
      .i_rd_en      (rdEn),
      .o_rd_data    (rdData),
      .o_rd_avail   (rdAvail),
      .o_rd_len     (rdLen),
      .i_rd_release (rdRelease),
      .i_flush      (flush)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wrByte(input logic [5:0] a, input logic [7:0] d);
      wrEn = 1'b1; wrAddr = a; wrData = d;
      tick();
      wrEn = 1'b0;
   endtask

   task automatic doCommit(input logic [6:0] len);
      wrCommit = 1'b1; wrLen = len;
      tick();
      wrCommit = 1'b0;
   endtask

   task automatic doRelease();
      rdRelease = 1'b1;
      tick();
      rdRelease = 1'b0;
   endtask

   task automatic doRead(input logic [3:0] a);
      rdEn = 1'b1; rdAddr = a;
      tick();
      rdEn = 1'b0;
   endtask

   task automatic test_reset();
      wrAddr = '0; wrData = '0; wrEn = 0; wrCommit = 0; wrLen = '0;
      rdAddr = '0; rdEn = 0; rdRelease = 0; flush = 0;
      rstN = 1'b0;
      repeat (3) tick();
      rstN = 1'b1;
      tick();
      tests++; if (wrRdy !== 1'b1) begin fails++; $display("[TB] FAIL reset_wr_rdy got %b expected 1", wrRdy); end
      tests++; if (rdAvail !== 1'b0) begin fails++; $display("[TB] FAIL reset_rd_avail got %b expected 0", rdAvail); end
      tests++; if (rdLen !== 7'd0) begin fails++; $display("[TB] FAIL reset_rd_len got %0d expected 0", rdLen); end
      tests++; if (rdData !== 32'h0) begin fails++; $display("[TB] FAIL reset_rd_data got %h expected 00000000", rdData); end
   endtask

   // Fill bank 0 with one small packet, read it back, then release it.
   task automatic test_basic();
      wrByte(6'd0, 8'h11); wrByte(6'd1, 8'h22); wrByte(6'd2, 8'h33); wrByte(6'd3, 8'h44);
      doCommit(7'd4);
      tests++; if (rdAvail !== 1'b1) begin fails++; $display("[TB] FAIL basic_avail got %b expected 1", rdAvail); end
      tests++; if (rdLen !== 7'd4) begin fails++; $display("[TB] FAIL basic_len got %0d expected 4", rdLen); end
      tests++; if (wrRdy !== 1'b1) begin fails++; $display("[TB] FAIL basic_wr_rdy got %b expected 1", wrRdy); end
      doRead(4'd0);
      tests++; if (rdData !== 32'h44332211) begin fails++; $display("[TB] FAIL basic_data got %h expected 44332211", rdData); end
      doRelease();
      tests++; if (rdAvail !== 1'b0 || rdLen !== 7'd0) begin fails++; $display("[TB] FAIL basic_release got avail %b len %0d expected 0 0", rdAvail, rdLen); end
   endtask

   // Bank 1: overwrite a single byte and check that the other lanes survive.
   task automatic test_byte_mask();
      wrByte(6'd4, 8'h01); wrByte(6'd5, 8'h02); wrByte(6'd6, 8'h03); wrByte(6'd7, 8'h04);
      wrByte(6'd5, 8'hAA);
      doCommit(7'd8);
      doRead(4'd1);
      tests++; if (rdData !== 32'h0403AA01) begin fails++; $display("[TB] FAIL byte_mask got %h expected 0403aa01", rdData); end
      doRelease();
   endtask

   // Both banks empty (wb == rb == 0): read and write the same word in one
   // cycle, then hold rd_en low while the word keeps changing.
   task automatic test_same_word();
      wrByte(6'd0, 8'hA0); wrByte(6'd1, 8'hA1); wrByte(6'd2, 8'hA2); wrByte(6'd3, 8'hA3);
      rdEn = 1'b1; rdAddr = 4'd0; wrEn = 1'b1; wrAddr = 6'd0; wrData = 8'hFF;
      tick();
      rdEn = 1'b0; wrEn = 1'b0;
      tests++; if (rdData !== 32'hA3A2A1A0) begin fails++; $display("[TB] FAIL rw_same_cycle got %h expected a3a2a1a0", rdData); end
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin wrEn = 1'b1; wrAddr = 6'd1; wrData = 8'hEE; end
         tick();
         wrEn = 1'b0;
         tests++; if (rdData !== 32'hA3A2A1A0) begin fails++; $display("[TB] FAIL rd_hold_%0d got %h expected a3a2a1a0", i, rdData); end
      end
      doRead(4'd0);
      tests++; if (rdData !== 32'hA3A2EEFF) begin fails++; $display("[TB] FAIL rd_after_hold got %h expected a3a2eeff", rdData); end
      tests++; if (rdAvail !== 1'b0) begin fails++; $display("[TB] FAIL rd_empty_avail got %b expected 0", rdAvail); end
   endtask

   // Fill both banks. While both are full, writes and commits must be dropped.
   task automatic test_two_banks();
      doCommit(7'd10);
      wrByte(6'd0, 8'hB0); wrByte(6'd1, 8'hB1); wrByte(6'd2, 8'hB2); wrByte(6'd3, 8'hB3);
      doCommit(7'd20);
      tests++; if (wrRdy !== 1'b0) begin fails++; $display("[TB] FAIL two_wr_rdy got %b expected 0", wrRdy); end
      tests++; if (rdLen !== 7'd10) begin fails++; $display("[TB] FAIL two_len0 got %0d expected 10", rdLen); end
      wrEn = 1'b1; wrAddr = 6'd0; wrData = 8'h55; wrCommit = 1'b1; wrLen = 7'd30;
      tick();
      wrEn = 1'b0; wrCommit = 1'b0;
      doRead(4'd0);
      tests++; if (rdData !== 32'hA3A2EEFF) begin fails++; $display("[TB] FAIL two_write_ignored got %h expected a3a2eeff", rdData); end
      tests++; if (rdLen !== 7'd10) begin fails++; $display("[TB] FAIL two_commit_ignored got %0d expected 10", rdLen); end
      doRelease();
      tests++; if (rdLen !== 7'd20) begin fails++; $display("[TB] FAIL two_len1 got %0d expected 20", rdLen); end
      tests++; if (wrRdy !== 1'b1) begin fails++; $display("[TB] FAIL two_wr_rdy_after got %b expected 1", wrRdy); end
      doRead(4'd0);
      tests++; if (rdData !== 32'hB3B2B1B0) begin fails++; $display("[TB] FAIL two_bank1_data got %h expected b3b2b1b0", rdData); end
   endtask

   // Bank 1 is full and bank 0 is free; commit and release in the same cycle.
   task automatic test_commit_release_same();
      wrCommit = 1'b1; wrLen = 7'd33; rdRelease = 1'b1;
      tick();
      wrCommit = 1'b0; rdRelease = 1'b0;
      tests++; if (rdAvail !== 1'b1) begin fails++; $display("[TB] FAIL cr_avail got %b expected 1", rdAvail); end
      tests++; if (wrRdy !== 1'b1) begin fails++; $display("[TB] FAIL cr_wr_rdy got %b expected 1", wrRdy); end
      tests++; if (rdLen !== 7'd33) begin fails++; $display("[TB] FAIL cr_len got %0d expected 33", rdLen); end
   endtask

   // Lengths above the bank size saturate at 64.
   task automatic test_len_clip();
      doCommit(7'd100);
      doRelease();
      tests++; if (rdLen !== 7'd64) begin fails++; $display("[TB] FAIL clip_100 got %0d expected 64", rdLen); end
      doRelease();
      doCommit(7'd64);
      tests++; if (rdLen !== 7'd64) begin fails++; $display("[TB] FAIL clip_64 got %0d expected 64", rdLen); end
      doRelease();
      doCommit(7'd127);
      tests++; if (rdLen !== 7'd64) begin fails++; $display("[TB] FAIL clip_127 got %0d expected 64", rdLen); end
      doRelease();
      doCommit(7'd63);
      tests++; if (rdLen !== 7'd63) begin fails++; $display("[TB] FAIL clip_63 got %0d expected 63", rdLen); end
      doRelease();
   endtask

   // Start with wb == rb == 1, so a working flush is visible when the pointers
   // return to bank 0.
   task automatic test_flush();
      doCommit(7'd7);
      doCommit(7'd9);
      tests++; if (wrRdy !== 1'b0 || rdLen !== 7'd7) begin fails++; $display("[TB] FAIL flush_pre got rdy %b len %0d expected 0 7", wrRdy, rdLen); end
      flush = 1'b1; wrCommit = 1'b1; wrLen = 7'd5; wrEn = 1'b1; wrAddr = 6'd0; wrData = 8'h99; rdRelease = 1'b1;
      tick();
      flush = 1'b0; wrCommit = 1'b0; wrEn = 1'b0; rdRelease = 1'b0;
      tests++; if (rdAvail !== 1'b0) begin fails++; $display("[TB] FAIL flush_avail got %b expected 0", rdAvail); end
      tests++; if (wrRdy !== 1'b1) begin fails++; $display("[TB] FAIL flush_wr_rdy got %b expected 1", wrRdy); end
      tests++; if (rdLen !== 7'd0) begin fails++; $display("[TB] FAIL flush_len got %0d expected 0", rdLen); end
      doRead(4'd0);
      tests++; if (rdData !== 32'hA3A2EEFF) begin fails++; $display("[TB] FAIL flush_rb0 got %h expected a3a2eeff", rdData); end
      wrByte(6'd0, 8'hC0); wrByte(6'd1, 8'hC1); wrByte(6'd2, 8'hC2); wrByte(6'd3, 8'hC3);
      doCommit(7'd4);
      doRead(4'd0);
      tests++; if (rdAvail !== 1'b1 || rdData !== 32'hC3C2C1C0) begin fails++; $display("[TB] FAIL flush_wb0 got avail %b data %h expected 1 c3c2c1c0", rdAvail, rdData); end
      doRelease();
   endtask

   // Start with wb == rb == 1. Fill bank 1, then pulse reset between edges
   // while a write is in flight.
   task automatic test_reset_mid();
      doCommit(7'd3);
      wrEn = 1'b1; wrAddr = 6'd0; wrData = 8'hD0;
      #2 rstN = 1'b0;
      #1;
      tests++; if (wrRdy !== 1'b1 || rdAvail !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_flags got rdy %b avail %b expected 1 0", wrRdy, rdAvail); end
      tests++; if (rdLen !== 7'd0 || rdData !== 32'h0) begin fails++; $display("[TB] FAIL rstmid_out got len %0d data %h expected 0 00000000", rdLen, rdData); end
      wrEn = 1'b0;
      #1 rstN = 1'b1;
      tick();
      doRead(4'd0);
      tests++; if (rdData !== 32'hC3C2C1C0) begin fails++; $display("[TB] FAIL rstmid_rb0 got %h expected c3c2c1c0", rdData); end
      wrByte(6'd0, 8'hE0); wrByte(6'd1, 8'hE1); wrByte(6'd2, 8'hE2); wrByte(6'd3, 8'hE3);
      doCommit(7'd2);
      doRead(4'd0);
      tests++; if (rdAvail !== 1'b1 || rdLen !== 7'd2) begin fails++; $display("[TB] FAIL rstmid_commit got avail %b len %0d expected 1 2", rdAvail, rdLen); end
      tests++; if (rdData !== 32'hE3E2E1E0) begin fails++; $display("[TB] FAIL rstmid_data got %h expected e3e2e1e0", rdData); end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_basic();
      test_byte_mask();
      test_same_word();
      test_two_banks();
      test_commit_release_same();
      test_len_clip();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
